// File: rtl/perf_pkg.sv
// Shared constants for the performance-statistics unit: overflow modes and
// the channel indices that datapath and display code use to address counters.
package perf_pkg;

  localparam int SAT_WRAP     = 0;
  localparam int SAT_SATURATE = 1;

  localparam int CH_CYCLES = 0;
  localparam int CH_UNCOND = 1;
  localparam int CH_COND   = 2;
  localparam int CH_TAKEN  = 3;
  localparam int CH_STALL  = 4;
  localparam int CH_FLUSH  = 5;

  localparam int RD_W = 32;

endpackage

// File: rtl/perf_counter_cell.sv
// One event channel: live counter with wrap or saturate behaviour, a sticky
// overflow flag and a snapshot shadow register.
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = SAT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             snap,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);

  logic at_max;

  assign at_max = &cnt;

  // NOTE: non-blocking assignments let shadow capture cnt as it was before this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      if (snap) shadow <= cnt;
      if (clr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (inc) begin
        if (at_max) begin
          ovf <= 1'b1;
          // Saturating counters simply hold all-ones.
          if (SAT_MODE == SAT_WRAP) cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of N_CH performance counters with snapshot shadows, sticky overflow
// flags, a registered read port and the syscall-print latch.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = SAT_WRAP,
  parameter int SEL_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [N_CH-1:0]  event_in,
  input  logic             clr,
  input  logic             snap,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic             rd_shadow,
  output logic [RD_W-1:0]  rd_data,
  output logic [N_CH-1:0]  ovf,
  input  logic             syscall_we,
  input  logic [31:0]      syscall_data,
  output logic [31:0]      syscall_out
);

  logic [CNT_W-1:0] cnt    [N_CH];
  logic [CNT_W-1:0] shadow [N_CH];
  logic [RD_W-1:0]  rd_next;

  for (genvar i = 0; i < N_CH; i++) begin : g_cell
    perf_counter_cell #(
      .CNT_W    (CNT_W),
      .SAT_MODE (SAT_MODE)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .inc    (run & event_in[i]),
      .clr    (clr),
      .snap   (snap),
      .cnt    (cnt[i]),
      .shadow (shadow[i]),
      .ovf    (ovf[i])
    );
  end

  // NOTE: default first so an unmatched rd_sel yields 0 instead of inferring a latch.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_sel == SEL_W'(i)) rd_next = RD_W'(rd_shadow ? shadow[i] : cnt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data     <= '0;
      syscall_out <= '0;
    end else begin
      rd_data <= rd_next;
      if (clr)                    syscall_out <= '0;
      else if (run && syscall_we) syscall_out <= syscall_data;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench: three bank configurations share one stimulus stream and
// are compared every cycle against an arithmetic model, plus literal spot checks.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        clr = 1'b0;
  logic        snap = 1'b0;
  logic        rd_shadow = 1'b0;
  logic        syscall_we = 1'b0;
  logic [7:0]  ev = '0;
  logic [2:0]  rd_sel = '0;
  logic [31:0] syscall_data = '0;

  logic [31:0] rd0, rd1, rd2, sc0, sc1, sc2;
  logic [7:0]  ovf0;
  logic [5:0]  ovf1, ovf2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // d0: default 8 x 32-bit wrap; d1: 6 x 8-bit wrap; d2: 6 x 8-bit saturate
  perf_counter_bank #(.N_CH(8), .CNT_W(32), .SAT_MODE(0), .SEL_W(3)) d0 (
    .clk(clk), .rst(rst), .run(run), .event_in(ev), .clr(clr), .snap(snap),
    .rd_sel(rd_sel), .rd_shadow(rd_shadow), .rd_data(rd0), .ovf(ovf0),
    .syscall_we(syscall_we), .syscall_data(syscall_data), .syscall_out(sc0));

  perf_counter_bank #(.N_CH(6), .CNT_W(8), .SAT_MODE(0), .SEL_W(3)) d1 (
    .clk(clk), .rst(rst), .run(run), .event_in(ev[5:0]), .clr(clr), .snap(snap),
    .rd_sel(rd_sel), .rd_shadow(rd_shadow), .rd_data(rd1), .ovf(ovf1),
    .syscall_we(syscall_we), .syscall_data(syscall_data), .syscall_out(sc1));

  perf_counter_bank #(.N_CH(6), .CNT_W(8), .SAT_MODE(1), .SEL_W(3)) d2 (
    .clk(clk), .rst(rst), .run(run), .event_in(ev[5:0]), .clr(clr), .snap(snap),
    .rd_sel(rd_sel), .rd_shadow(rd_shadow), .rd_data(rd2), .ovf(ovf2),
    .syscall_we(syscall_we), .syscall_data(syscall_data), .syscall_out(sc2));

  function automatic int unsigned nch_of(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic longint unsigned max_of(input int k);
    return (k == 0) ? 64'hFFFF_FFFF : 64'hFF;
  endfunction

  function automatic bit sat_of(input int k);
    return (k == 2);
  endfunction

  longint unsigned m_cnt [3][8];
  longint unsigned m_sh  [3][8];
  longint unsigned m_rd  [3];
  logic [7:0]      m_ovf [3];
  logic [31:0]     m_sc;

  // Reference model: counts as plain integers; overflow is "count + 1 exceeds max".
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 8; i++) begin
          m_cnt[k][i] <= 0;
          m_sh[k][i]  <= 0;
        end
        m_ovf[k] <= '0;
        m_rd[k]  <= 0;
      end
      m_sc <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_rd[k] <= (rd_sel < nch_of(k)) ? (rd_shadow ? m_sh[k][rd_sel] : m_cnt[k][rd_sel]) : 0;
        for (int i = 0; i < 8; i++) begin
          if (i < nch_of(k)) begin
            if (snap) m_sh[k][i] <= m_cnt[k][i];
            if (clr) begin
              m_cnt[k][i] <= 0;
              m_ovf[k][i] <= 1'b0;
            end else if (run && ev[i]) begin
              if (m_cnt[k][i] + 64'd1 > max_of(k)) begin
                m_ovf[k][i] <= 1'b1;
                m_cnt[k][i] <= sat_of(k) ? max_of(k) : (m_cnt[k][i] + 64'd1) % (max_of(k) + 64'd1);
              end else begin
                m_cnt[k][i] <= m_cnt[k][i] + 64'd1;
              end
            end
          end
        end
      end
      if (clr)                    m_sc <= '0;
      else if (run && syscall_we) m_sc <= syscall_data;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check("cmp rd_data d0", rd0, m_rd[0]);
    check("cmp rd_data d1", rd1, m_rd[1]);
    check("cmp rd_data d2", rd2, m_rd[2]);
    check("cmp ovf d0", ovf0, m_ovf[0]);
    check("cmp ovf d1", {2'b00, ovf1}, m_ovf[1]);
    check("cmp ovf d2", {2'b00, ovf2}, m_ovf[2]);
    check("cmp syscall d0", sc0, m_sc);
    check("cmp syscall d1", sc1, m_sc);
    check("cmp syscall d2", sc2, m_sc);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_rd(input string name, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2);
    check({name, " d0"}, rd0, e0);
    check({name, " d1"}, rd1, e1);
    check({name, " d2"}, rd2, e2);
  endtask

  initial begin
    // Reset held while strobes toggle
    ev = 8'hA5; run = 1'b1; snap = 1'b1; syscall_we = 1'b1; syscall_data = 32'hDEAD_BEEF;
    for (int t = 0; t < 3; t++) begin
      ev = ~ev;
      tick();
    end
    check_rd("reset rd_data", 0, 0, 0);
    check("reset ovf d0", ovf0, 0);
    check("reset syscall d0", sc0, 0);

    rst = 1'b1; run = 1'b1; ev = 8'h01; snap = 1'b0; syscall_we = 1'b0; syscall_data = '0;
    rd_sel = 3'd0; rd_shadow = 1'b0;
    tick(5);
    ev = '0;
    tick();
    check_rd("first counts", 5, 5, 5);
    check("model pin first counts", m_rd[1], 5);

    // Freeze then resume
    run = 1'b0; ev = 8'hFF;
    tick(10);
    check_rd("frozen", 5, 5, 5);
    run = 1'b1;
    tick(3);
    ev = '0;
    tick();
    check_rd("resume ch0", 8, 8, 8);
    rd_sel = 3'd4;
    tick();
    check_rd("resume ch4", 3, 3, 3);

    // Wrap versus saturate on ch2
    clr = 1'b1;
    tick();
    clr = 1'b0; ev = 8'h04;
    tick(257);
    ev = '0; rd_sel = 3'd2;
    tick();
    check_rd("257 incs", 257, 1, 255);
    check("model pin wrap", m_rd[1], 1);
    check("ovf after 257 d0", ovf0, 0);
    check("ovf after 257 d1", ovf1, 6'h04);
    check("ovf after 257 d2", ovf2, 6'h04);
    ev = 8'h04;
    tick(43);
    ev = '0;
    tick();
    check_rd("300 incs", 300, 44, 255);
    check("model pin saturate", m_rd[2], 255);

    // clr beats a same-cycle event
    clr = 1'b1; ev = 8'h04;
    tick();
    clr = 1'b0; ev = '0;
    check("ovf cleared d1", ovf1, 0);
    check("ovf cleared d2", ovf2, 0);
    tick();
    check_rd("cleared ch2", 0, 0, 0);

    // snap + clr + event captures pre-clear value
    ev = 8'h02;
    tick(7);
    snap = 1'b1; clr = 1'b1;
    tick();
    snap = 1'b0; clr = 1'b0; ev = '0; rd_sel = 3'd1; rd_shadow = 1'b1;
    tick();
    check_rd("shadow after snap+clr", 7, 7, 7);
    rd_shadow = 1'b0;
    tick();
    check_rd("live after snap+clr", 0, 0, 0);

    // snap + event captures pre-increment value
    ev = 8'h02;
    tick(3);
    snap = 1'b1;
    tick();
    snap = 1'b0; ev = '0; rd_shadow = 1'b1;
    tick();
    check_rd("shadow after snap+event", 3, 3, 3);
    rd_shadow = 1'b0;
    tick();
    check_rd("live after snap+event", 4, 4, 4);

    // Syscall latch
    run = 1'b1; syscall_we = 1'b1; syscall_data = 32'h0000_002A;
    tick();
    check("syscall run d0", sc0, 42);
    check("syscall run d2", sc2, 42);
    run = 1'b0; syscall_data = 32'h0000_1234;
    tick();
    check("syscall halted d1", sc1, 42);
    run = 1'b1; clr = 1'b1;
    tick();
    check("syscall clr d0", sc0, 0);
    syscall_we = 1'b0; clr = 1'b0;

    // Read mux: channel i holds i+1
    for (int t = 0; t < 8; t++) begin
      ev = 8'hFF << t;
      tick();
    end
    ev = '0; rd_sel = 3'd7;
    tick();
    check_rd("rd_sel 7", 8, 0, 0);
    rd_sel = 3'd6;
    tick();
    check_rd("rd_sel 6", 7, 0, 0);
    for (int s = 0; s < 6; s++) begin
      rd_sel = 3'(s);
      #1;
      check("rd lag before edge d1", rd1, (s == 0) ? 0 : s);
      tick();
      check_rd("rd sweep", s + 1, s + 1, s + 1);
    end

    // Async reset mid-count
    ev = 8'hFF; rd_sel = 3'd3;
    tick(2);
    #3 rst = 1'b0;
    #1;
    check_rd("async reset", 0, 0, 0);
    check("async reset ovf d2", ovf2, 0);
    tick();
    rst = 1'b1; ev = '0;
    tick();
    check_rd("counters zero after reset", 0, 0, 0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
